regfile_sb: RTL and testbench

- Parametrised successor of the core's 2R1W integer register file, for the next-gen pipeline: configurable width, depth and read-port count.
- Two write-back ports: a single-cycle ALU path and a long-latency load/MUL path.
- Per-register busy-bit scoreboard, set at issue and cleared at write-back; used by decode to detect RAW/WAW hazards.
- Write-to-read bypass, and a flush that drops outstanding reservations.

---
 rtl/regfile_sb.sv | 73 +++++++
 tb/tb_regfile_sb.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Parametrised multi-read, dual-write-back integer register file with a per-register
// busy-bit scoreboard for RAW/WAW hazard detection, write-to-read bypass and flush.
module regfile_sb #(
    parameter int  XLEN   = 32,
    parameter int  NREGS  = 32,
    parameter int  NUM_RP = 2,
    parameter bit  BYPASS = 1'b1,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush_i,
    input  logic [NUM_RP*AW-1:0]   rd_addr_i,
    output logic [NUM_RP*XLEN-1:0] rd_data_o,
    output logic [NUM_RP-1:0]      rd_busy_o,
    input  logic                   iss_valid_i,
    input  logic [AW-1:0]          iss_rd_i,
    output logic                   iss_ready_o,
    input  logic                   wb0_we_i,
    input  logic [AW-1:0]          wb0_addr_i,
    input  logic [XLEN-1:0]        wb0_data_i,
    input  logic                   wb1_we_i,
    input  logic [AW-1:0]          wb1_addr_i,
    input  logic [XLEN-1:0]        wb1_data_i
);

    logic [XLEN-1:0]  mem_q [NREGS];
    logic [NREGS-1:0] busy_q, busy_d;
    logic             iss_wb_hit;

    // Entry 0 is only ever reset, never written, so it reads as zero naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (wb1_we_i && wb1_addr_i == AW'(i))      mem_q[i] <= wb1_data_i;
                else if (wb0_we_i && wb0_addr_i == AW'(i)) mem_q[i] <= wb0_data_i;
            end
        end
    end

    for (genvar k = 0; k < NUM_RP; k++) begin : g_rp
        logic [AW-1:0] a;
        logic          hit0, hit1;
        assign a    = rd_addr_i[k*AW +: AW];
        assign hit0 = wb0_we_i && (wb0_addr_i == a) && (a != '0);
        assign hit1 = wb1_we_i && (wb1_addr_i == a) && (a != '0);
        assign rd_data_o[k*XLEN +: XLEN] = (BYPASS && hit1) ? wb1_data_i :
                                           (BYPASS && hit0) ? wb0_data_i : mem_q[a];
        assign rd_busy_o[k] = busy_q[a] && !(BYPASS && (hit0 || hit1)) && (a != '0);
    end

    // A write-back landing on the destination this cycle frees it, so the issue may go.
    assign iss_wb_hit  = (wb0_we_i && wb0_addr_i == iss_rd_i) ||
                         (wb1_we_i && wb1_addr_i == iss_rd_i);
    assign iss_ready_o = !flush_i && ((iss_rd_i == '0) || !busy_q[iss_rd_i] || iss_wb_hit);

    always_comb begin
        busy_d = busy_q;
        if (wb0_we_i) busy_d[wb0_addr_i] = 1'b0;
        if (wb1_we_i) busy_d[wb1_addr_i] = 1'b0;
        if (iss_valid_i && iss_ready_o && iss_rd_i != '0) busy_d[iss_rd_i] = 1'b1;
        if (flush_i) busy_d = '0;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench: two regfile_sb configurations driven together and compared each
// cycle against an architectural model (register array + busy flags), plus directed checks.
module tb_regfile_sb;

    typedef struct {
        logic            flush;
        logic [3:0][4:0] rd;
        logic            iss_v;
        logic [4:0]      iss_rd;
        logic            w0;
        logic [4:0]      a0;
        logic [63:0]     d0;
        logic            w1;
        logic [4:0]      a1;
        logic [63:0]     d1;
    } stim_t;

    logic         clk = 1'b0;
    logic         rst_n;
    stim_t        st [2];
    logic [63:0]  a_rd_data;
    logic [1:0]   a_rd_busy;
    logic         a_ready;
    logic [191:0] b_rd_data;
    logic [2:0]   b_rd_busy;
    logic         b_ready;

    logic [63:0]  mm [2][32];
    logic         mb [2][32];
    int           n_tests = 0;
    int           n_fail  = 0;

    always #5 clk = ~clk;

    regfile_sb #(.XLEN(32), .NREGS(32), .NUM_RP(2), .BYPASS(1'b1)) u_a (
        .clk(clk), .rst_n(rst_n), .flush_i(st[0].flush),
        .rd_addr_i({st[0].rd[1], st[0].rd[0]}),
        .rd_data_o(a_rd_data), .rd_busy_o(a_rd_busy),
        .iss_valid_i(st[0].iss_v), .iss_rd_i(st[0].iss_rd), .iss_ready_o(a_ready),
        .wb0_we_i(st[0].w0), .wb0_addr_i(st[0].a0), .wb0_data_i(st[0].d0[31:0]),
        .wb1_we_i(st[0].w1), .wb1_addr_i(st[0].a1), .wb1_data_i(st[0].d1[31:0])
    );

    regfile_sb #(.XLEN(64), .NREGS(16), .NUM_RP(3), .BYPASS(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n), .flush_i(st[1].flush),
        .rd_addr_i({st[1].rd[2][3:0], st[1].rd[1][3:0], st[1].rd[0][3:0]}),
        .rd_data_o(b_rd_data), .rd_busy_o(b_rd_busy),
        .iss_valid_i(st[1].iss_v), .iss_rd_i(st[1].iss_rd[3:0]), .iss_ready_o(b_ready),
        .wb0_we_i(st[1].w0), .wb0_addr_i(st[1].a0[3:0]), .wb0_data_i(st[1].d0),
        .wb1_we_i(st[1].w1), .wb1_addr_i(st[1].a1[3:0]), .wb1_data_i(st[1].d1)
    );

    function automatic int nrp(int d);
        return (d == 0) ? 2 : 3;
    endfunction

    function automatic logic [63:0] dmask(int d);
        return (d == 0) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    endfunction

    function automatic bit byp(int d);
        return d == 0;
    endfunction

    function automatic bit wb_hit(int d, logic [4:0] a);
        return (a != 0) && ((st[d].w0 && st[d].a0 == a) || (st[d].w1 && st[d].a1 == a));
    endfunction

    function automatic logic [63:0] exp_data(int d, int k);
        logic [4:0] a = st[d].rd[k];
        if (a == 0) return 64'h0;
        if (byp(d) && st[d].w1 && st[d].a1 == a) return st[d].d1 & dmask(d);
        if (byp(d) && st[d].w0 && st[d].a0 == a) return st[d].d0 & dmask(d);
        return mm[d][a];
    endfunction

    function automatic logic exp_busy(int d, int k);
        logic [4:0] a = st[d].rd[k];
        return (a != 0) && mb[d][a] && !(byp(d) && wb_hit(d, a));
    endfunction

    function automatic logic exp_ready(int d);
        logic [4:0] r = st[d].iss_rd;
        return !st[d].flush && ((r == 0) || !mb[d][r] || wb_hit(d, r));
    endfunction

    function automatic logic [63:0] obs_data(int d, int k);
        return (d == 0) ? {32'h0, a_rd_data[k*32 +: 32]} : b_rd_data[k*64 +: 64];
    endfunction

    function automatic logic obs_busy(int d, int k);
        return (d == 0) ? a_rd_busy[k] : b_rd_busy[k];
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++)
            for (int r = 0; r < 32; r++) begin
                mm[d][r] = 64'h0;
                mb[d][r] = 1'b0;
            end
    endtask

    task automatic idle();
        for (int d = 0; d < 2; d++) begin
            st[d].flush = 0; st[d].rd = '0; st[d].iss_v = 0; st[d].iss_rd = 0;
            st[d].w0 = 0; st[d].a0 = 0; st[d].d0 = 0;
            st[d].w1 = 0; st[d].a1 = 0; st[d].d1 = 0;
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < nrp(d); k++) begin
                chk($sformatf("d%0d_rdata%0d", d, k), obs_data(d, k), exp_data(d, k));
                chk($sformatf("d%0d_rbusy%0d", d, k), 64'(obs_busy(d, k)), 64'(exp_busy(d, k)));
            end
            chk($sformatf("d%0d_ready", d), 64'((d == 0) ? a_ready : b_ready), 64'(exp_ready(d)));
        end
    endtask

    task automatic settle();
        @(negedge clk);
        check_all();
    endtask

    // Architectural effect of one clock edge on the reference state.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else begin
            for (int d = 0; d < 2; d++) begin
                bit acc = st[d].iss_v && exp_ready(d);
                if (st[d].w0 && st[d].a0 != 0) mm[d][st[d].a0] = st[d].d0 & dmask(d);
                if (st[d].w1 && st[d].a1 != 0) mm[d][st[d].a1] = st[d].d1 & dmask(d);
                if (st[d].w0) mb[d][st[d].a0] = 1'b0;
                if (st[d].w1) mb[d][st[d].a1] = 1'b0;
                if (acc && st[d].iss_rd != 0) mb[d][st[d].iss_rd] = 1'b1;
                if (st[d].flush) for (int r = 0; r < 32; r++) mb[d][r] = 1'b0;
                mb[d][0] = 1'b0;
            end
        end
        #1;
    endtask

    task automatic step();
        settle();
        tick();
    endtask

    function automatic logic [4:0] raddr(int d);
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, (d == 0) ? 31 : 15));
        return 5'($urandom_range(0, 7));
    endfunction

    initial begin
        rst_n = 1'b0;
        idle();
        model_reset();
        step();
        settle();
        chk("rst_ready", 64'(a_ready), 64'h1);
        chk("rst_busy", 64'(a_rd_busy), 64'h0);
        tick();
        rst_n = 1'b1;

        // x5 written, then reset asserted mid-run
        st[0].w0 = 1; st[0].a0 = 5; st[0].d0 = 64'hDEAD_BEEF;
        step();
        idle(); st[0].rd[0] = 5;
        settle(); chk("x5_written", obs_data(0, 0), 64'hDEAD_BEEF); tick();
        rst_n = 1'b0; model_reset();
        settle(); chk("rst_x5", obs_data(0, 0), 64'h0); chk("rst_x5_busy", 64'(a_rd_busy[0]), 64'h0); tick();
        rst_n = 1'b1;
        settle(); chk("post_rst_x5", obs_data(0, 0), 64'h0); tick();

        // wb1 beats wb0 on the same address
        idle(); st[0].rd[0] = 3;
        st[0].w0 = 1; st[0].a0 = 3; st[0].d0 = 64'h11;
        st[0].w1 = 1; st[0].a1 = 3; st[0].d1 = 64'h22;
        settle(); chk("byp_pri", obs_data(0, 0), 64'h22); tick();
        idle(); st[0].rd[0] = 3;
        settle(); chk("arr_pri", obs_data(0, 0), 64'h22); tick();

        // RAW: issue then write-back through wb1
        idle(); st[0].iss_v = 1; st[0].iss_rd = 7;
        step();
        idle(); st[0].rd[0] = 7;
        settle(); chk("raw_busy", 64'(a_rd_busy[0]), 64'h1); tick();
        st[0].w1 = 1; st[0].a1 = 7; st[0].d1 = 64'hABCD;
        settle(); chk("raw_wb_busy", 64'(a_rd_busy[0]), 64'h0); chk("raw_wb_data", obs_data(0, 0), 64'hABCD); tick();

        // WAW stall, then set-over-clear
        idle(); st[0].iss_v = 1; st[0].iss_rd = 9;
        step();
        settle(); chk("waw_stall", 64'(a_ready), 64'h0); tick();
        st[0].w0 = 1; st[0].a0 = 9; st[0].d0 = 64'h99;
        settle(); chk("waw_wb_ready", 64'(a_ready), 64'h1); tick();
        idle(); st[0].rd[0] = 9;
        settle(); chk("set_over_clear", 64'(a_rd_busy[0]), 64'h1); tick();

        // Flush with pending issue and write-back
        idle(); st[0].iss_v = 1; st[0].iss_rd = 4; step();
        st[0].iss_rd = 8; step();
        idle(); st[0].flush = 1; st[0].iss_v = 1; st[0].iss_rd = 10;
        st[0].w0 = 1; st[0].a0 = 4; st[0].d0 = 64'h55; st[0].rd[0] = 8;
        settle(); chk("flush_ready", 64'(a_ready), 64'h0); tick();
        idle(); st[0].rd[0] = 4; st[0].rd[1] = 10;
        settle();
        chk("flush_x4", obs_data(0, 0), 64'h55);
        chk("flush_x4_busy", 64'(a_rd_busy[0]), 64'h0);
        chk("flush_x10_busy", 64'(a_rd_busy[1]), 64'h0);
        tick();
        st[0].rd[0] = 8;
        settle(); chk("flush_x8_busy", 64'(a_rd_busy[0]), 64'h0); tick();

        // Narrow/wide config without bypass: x0 and same-cycle write visibility
        idle(); st[1].w1 = 1; st[1].a1 = 2; st[1].d1 = 64'h1111_2222_3333_4444;
        step();
        idle();
        st[1].w0 = 1; st[1].a0 = 0; st[1].d0 = 64'hFFFF;
        st[1].iss_v = 1; st[1].iss_rd = 0;
        st[1].w1 = 1; st[1].a1 = 2; st[1].d1 = 64'hAAAA_BBBB_CCCC_DDDD;
        st[1].rd[1] = 2;
        settle();
        chk("b_x0_data", obs_data(1, 0), 64'h0);
        chk("b_x0_busy", 64'(b_rd_busy[0]), 64'h0);
        chk("b_x0_ready", 64'(b_ready), 64'h1);
        chk("b_nobyp_old", obs_data(1, 1), 64'h1111_2222_3333_4444);
        tick();
        idle(); st[1].rd[1] = 2; st[1].rd[2] = 2;
        settle();
        chk("b_new_val", obs_data(1, 2), 64'hAAAA_BBBB_CCCC_DDDD);
        chk("b_x0_stays", obs_data(1, 0), 64'h0);
        tick();

        // Random traffic on both configurations
        for (int n = 0; n < 600; n++) begin
            for (int d = 0; d < 2; d++) begin
                st[d].flush  = ($urandom_range(0, 15) == 0);
                for (int k = 0; k < 4; k++) st[d].rd[k] = (k < nrp(d)) ? raddr(d) : 5'd0;
                st[d].iss_v  = $urandom_range(0, 1) == 1;
                st[d].iss_rd = raddr(d);
                st[d].w0     = $urandom_range(0, 9) < 4;
                st[d].a0     = raddr(d);
                st[d].d0     = {$urandom, $urandom};
                st[d].w1     = $urandom_range(0, 9) < 3;
                st[d].a1     = raddr(d);
                st[d].d1     = {$urandom, $urandom};
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
